// File: rtl/bin2bcd_seq_ctrl.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one digit corrected per cycle
// through a shared external 4-bit adder; results and flags are registered at done.
`timescale 1ns/1ps
module bin2bcd_seq_ctrl #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  ovf,
  output logic                  err,
  output logic [3:0]            add_x,
  output logic [3:0]            add_y,
  output logic                  add_cin,
  input  logic [3:0]            add_s,
  input  logic                  add_cout
);

  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {IDLE, ADJ, SHIFT, DONE} state_t;

  state_t                state_q;
  logic [BIN_W-1:0]      sr_q;
  logic [4*DIGITS-1:0]   d_q;
  logic [CW-1:0]         bcnt_q;
  logic [DW-1:0]         dix_q;
  logic                  ovf_s_q;
  logic                  err_s_q;
  logic                  busy_q;
  logic                  done_q;
  logic [4*DIGITS-1:0]   bcd_q;
  logic                  ovf_q;
  logic                  err_q;
  logic [3:0]            cur_dig;

  always_comb begin
    cur_dig = 4'd0;
    for (int k = 0; k < DIGITS; k++) begin
      if (dix_q == DW'(k)) cur_dig = d_q[4*k +: 4];
    end
  end

  // Operands are only presented while correcting, so the adder idles at 0+0.
  assign add_x   = (state_q == ADJ) ? cur_dig : 4'd0;
  assign add_y   = (state_q == ADJ && cur_dig >= 4'd5) ? 4'd3 : 4'd0;
  assign add_cin = 1'b0;

  assign busy    = busy_q;
  assign done    = done_q;
  assign bcd_out = bcd_q;
  assign ovf     = ovf_q;
  assign err     = err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      d_q     <= '0;
      bcnt_q  <= '0;
      dix_q   <= '0;
      ovf_s_q <= 1'b0;
      err_s_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            sr_q    <= bin_in;
            d_q     <= '0;
            bcnt_q  <= '0;
            dix_q   <= '0;
            ovf_s_q <= 1'b0;
            err_s_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= ADJ;
          end
        end
        ADJ: begin
          for (int k = 0; k < DIGITS; k++) begin
            if (dix_q == DW'(k)) d_q[4*k +: 4] <= add_s;
          end
          if (add_cout) err_s_q <= 1'b1;
          if (dix_q == DW'(DIGITS - 1)) begin
            dix_q   <= '0;
            state_q <= SHIFT;
          end else begin
            dix_q <= dix_q + 1'b1;
          end
        end
        SHIFT: begin
          // The final shift lands directly in bcd_out along with the sticky flags.
          d_q    <= {d_q[4*DIGITS-2:0], sr_q[BIN_W-1]};
          sr_q   <= sr_q << 1;
          bcnt_q <= bcnt_q + 1'b1;
          if (d_q[4*DIGITS-1]) ovf_s_q <= 1'b1;
          if (bcnt_q == CW'(BIN_W - 1)) begin
            bcd_q   <= {d_q[4*DIGITS-2:0], sr_q[BIN_W-1]};
            ovf_q   <= ovf_s_q | d_q[4*DIGITS-1];
            err_q   <= err_s_q;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            state_q <= ADJ;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
